gmem_ctrl: RTL

GMEM_CTRL -- requirements
Module: gmem_ctrl

---
 rtl/gmem_ctrl_if.sv | 23 ++
 rtl/gmem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gmem_ctrl_if.sv
// CPU <-> global memory controller request/response bundle.
// The CPU drives the request fields and holds them until mem_ready.
interface gmem_ctrl_if;
   logic        Gmem_R;
   logic        Gmem_W;
   logic [31:0] GmemAddr;
   logic [31:0] dataOut;
   logic [1:0]  MEM_C;
   logic        MEM_S;
   logic [31:0] dataIn;
   logic        mem_ready;
   logic        mem_err;

   modport master (
      output Gmem_R, Gmem_W, GmemAddr, dataOut, MEM_C, MEM_S,
      input  dataIn, mem_ready, mem_err
   );

   modport slave (
      input  Gmem_R, Gmem_W, GmemAddr, dataOut, MEM_C, MEM_S,
      output dataIn, mem_ready, mem_err
   );
endinterface

// File: rtl/gmem_ctrl.sv
// Global memory controller: text and data word RAMs with byte/halfword
// loads, read-modify-write sub-word stores and fault reporting.
module gmem_ctrl #(
   parameter int          REGION_WORDS = 1024,
   parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
   parameter logic [31:0] DATA_BASE    = 32'h1001_0000
) (
   input logic        clk,
   input logic        rst,
   gmem_ctrl_if.slave bus
);

   localparam int          AW           = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
   localparam logic [31:0] REGION_BYTES = 32'(4 * REGION_WORDS);
   localparam logic [1:0]  SZ_WORD      = 2'b00;
   localparam logic [1:0]  SZ_HALF      = 2'b01;
   localparam logic [1:0]  SZ_BYTE      = 2'b10;

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, RESP} state_t;

   state_t state, state_nxt;

   logic [31:0] text_mem [REGION_WORDS];
   logic [31:0] data_mem [REGION_WORDS];

   logic [31:0] text_off, data_off;
   logic        text_hit, data_hit, fault;
   logic [AW-1:0] live_idx;

   logic          accept, ram_re, ram_we, ram_sel_data;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_wdata;

   logic          sel_data_q, sign_q, fault_q;
   logic [AW-1:0] idx_q;
   logic [1:0]    lane_q, size_q;
   logic [15:0]   wdata_q;
   logic [31:0]   rd_word, dout_q, merged, extracted;

   assign text_off = bus.GmemAddr - TEXT_BASE;
   assign data_off = bus.GmemAddr - DATA_BASE;
   assign text_hit = (bus.GmemAddr >= TEXT_BASE) && (text_off < REGION_BYTES);
   assign data_hit = (bus.GmemAddr >= DATA_BASE) && (data_off < REGION_BYTES);
   assign live_idx = data_hit ? data_off[AW+1:2] : text_off[AW+1:2];

   always_comb begin
      fault = 1'b0;
      if (!text_hit && !data_hit)                           fault = 1'b1;
      if (bus.MEM_C == 2'b11)                               fault = 1'b1;
      if (bus.MEM_C == SZ_HALF && bus.GmemAddr[0])          fault = 1'b1;
      if (bus.MEM_C == SZ_WORD && bus.GmemAddr[1:0] != 2'b00) fault = 1'b1;
      if (bus.Gmem_R && bus.Gmem_W)                         fault = 1'b1;
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      ram_re       = 1'b0;
      ram_we       = 1'b0;
      ram_sel_data = sel_data_q;
      ram_idx      = idx_q;
      ram_wdata    = bus.dataOut;
      case (state)
         IDLE: begin
            if (bus.Gmem_R || bus.Gmem_W) begin
               accept       = 1'b1;
               ram_sel_data = data_hit;
               ram_idx      = live_idx;
               if (fault) begin
                  state_nxt = RESP;
               end else if (bus.Gmem_R) begin
                  ram_re    = 1'b1;
                  state_nxt = RD;
               end else if (bus.MEM_C == SZ_WORD) begin
                  ram_we    = 1'b1;
                  state_nxt = RESP;
               end else begin
                  ram_re    = 1'b1;
                  state_nxt = RMW_RD;
               end
            end
         end
         RD:     state_nxt = RESP;
         RMW_RD: state_nxt = RMW_WR;
         RMW_WR: begin
            ram_we    = 1'b1;
            ram_wdata = merged;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Reset wins over any write landing on the same edge.
      if (rst) ram_we = 1'b0;
   end

   always_comb begin
      merged = rd_word;
      if (size_q == SZ_BYTE) merged[8*lane_q +: 8]     = wdata_q[7:0];
      else                   merged[16*lane_q[1] +: 16] = wdata_q;
   end

   always_comb begin
      case (size_q)
         SZ_BYTE: extracted = {{24{sign_q & rd_word[8*lane_q + 7]}}, rd_word[8*lane_q +: 8]};
         SZ_HALF: extracted = {{16{sign_q & rd_word[16*lane_q[1] + 15]}}, rd_word[16*lane_q[1] +: 16]};
         default: extracted = rd_word;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         if (accept)       fault_q <= fault;
         if (state == RD)  dout_q  <= extracted;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sel_data_q <= data_hit;
         idx_q      <= live_idx;
         lane_q     <= bus.GmemAddr[1:0];
         size_q     <= bus.MEM_C;
         sign_q     <= bus.MEM_S;
         wdata_q    <= bus.dataOut[15:0];
      end
   end

   // NOTE: RAM arrays carry no reset; their contents survive rst by design.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         if (ram_sel_data) data_mem[ram_idx] <= ram_wdata;
         else              text_mem[ram_idx] <= ram_wdata;
      end
      if (ram_re) rd_word <= ram_sel_data ? data_mem[ram_idx] : text_mem[ram_idx];
   end

   assign bus.dataIn    = dout_q;
   assign bus.mem_ready = (state == RESP);
   assign bus.mem_err   = (state == RESP) && fault_q;

endmodule
